triangle_fetcher: RTL and testbench
===================================

TRIANGLE_FETCHER -- requirements
Module: triangle_fetcher

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of vertex-memory word address and triangle index.
REQ-002 SHALL have parameter WORDS_PER_TRI, default 9, memory words per triangle (p1xyz, p2xyz, p3xyz, in that order).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port sreset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port go  input  1  single-cycle request to process a triangle batch.
REQ-006 SHALL have port base_addr  input  ADDR_W  word address of triangle 0, sampled on accepted go.
REQ-007 SHALL have port tri_count  input  ADDR_W  triangles in batch, sampled on accepted go.
REQ-008 SHALL have port mem_rd  output  1  vertex-memory read strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  vertex-memory word address.
REQ-010 SHALL have port mem_rdata  input  32  read data, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have ports p1, p2, p3  output  32 x3 each  NDC fp32 vertex (x,y,z) to the shader stage.
REQ-012 SHALL have port shade_start  output  1  one-cycle start pulse to the shader stage.
REQ-013 SHALL have ports shade_done  input  1, shade_color  input  4  shader completion and result.
REQ-014 SHALL have ports tri_valid  output  1, tri_ready  input  1, tri_color  output  4, tri_index  output  ADDR_W  result stream to the rasterizer.
REQ-015 SHALL have ports busy  output  1 (not IDLE) and batch_done  output  1 (one-cycle pulse at batch end).

Function
REQ-016 SHALL implement states IDLE, FETCH, SHADE_START, SHADE_WAIT, EMIT, FINISH.
REQ-017 IDLE: go=1 with tri_count>0 -> FETCH, n=0; go=1 with tri_count=0 -> FINISH; go ignored in every other state.
REQ-018 FETCH: issue mem_rd for k=0..8 on 9 consecutive cycles, mem_addr = base_addr + WORDS_PER_TRI*n + k, modulo 2^ADDR_W.
REQ-019 FETCH: capture mem_rdata one cycle after each read into vertex word k (k0-2 -> p1[0..2], k3-5 -> p2, k6-8 -> p3); FETCH lasts exactly 10 cycles, then SHADE_START.
REQ-020 SHADE_START: shade_start=1 for exactly one cycle, then SHADE_WAIT.
REQ-021 SHADE_WAIT: shade_done is ignored in the shade_start cycle; first cycle with shade_done=1 captures shade_color into tri_color and goes to EMIT; wait is unbounded.
REQ-022 p1/p2/p3 SHALL be held stable from SHADE_START through the end of EMIT.
REQ-023 EMIT: tri_valid=1, tri_index=n, tri_color stable until the cycle tri_valid&tri_ready; transfer then increments n.
REQ-024 After transfer: n+1 == tri_count -> FINISH, else -> FETCH for next triangle; no bubble beyond the state change.
REQ-025 FINISH: batch_done=1 for one cycle, -> IDLE.
REQ-026 tri_ready while tri_valid=0 SHALL have no effect; tri_valid SHALL never drop before transfer.
REQ-027 mem_rd SHALL be 0 outside FETCH issue cycles; mem_addr SHALL be 0 when mem_rd=0.

Reset
REQ-028 sreset=1 SHALL force IDLE from any state, including mid-FETCH or mid-EMIT, discarding the batch.
REQ-029 Reset values: mem_rd, mem_addr, shade_start, tri_valid, tri_color, tri_index, busy, batch_done, p1/p2/p3 all zero.
REQ-030 Reset SHALL take priority over go in the same cycle.

Structure
REQ-031 State enum, WORDS_PER_TRI and VERTS_PER_TRI=3 SHALL live in the shared graphics package.
REQ-032 The nine vertex words SHALL be held in reg_32 instances; no other sub-module.

Verification
REQ-033 base_addr=0x0100, tri_count=1, memory words 0x3F800000+k -> reads at 0x0100..0x0108, p1[0]=0x3F800000, p3[2]=0x3F800008, one shade_start, batch_done after transfer.
REQ-034 tri_count=3, base_addr=0x0000, shader returns colors 5,9,2 -> tri_index 0,1,2 with tri_color 5,9,2; third fetch starts at address 0x0012.
REQ-035 tri_ready held 0 for 20 cycles in EMIT -> tri_valid, tri_color, p1..p3 unchanged; transfer on first ready cycle.
REQ-036 tri_count=0 -> no mem_rd, no shade_start, batch_done one cycle after go.
REQ-037 base_addr=0xFFFC, tri_count=1 -> addresses 0xFFFC..0xFFFF, 0x0000..0x0004.
REQ-038 sreset asserted at 5th FETCH cycle -> next cycle IDLE, all outputs zero; new go then fetches from the newly sampled base_addr.

Source files
------------

// File: rtl/triangle_fetcher_pkg.sv
// Shared graphics definitions for the triangle fetcher: FSM states and
// triangle geometry constants.
package triangle_fetcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHADE_START,
        SHADE_WAIT,
        EMIT,
        FINISH
    } state_e;

    localparam int WORDS_PER_TRI   = 9;
    localparam int VERTS_PER_TRI   = 3;
    localparam int COORDS_PER_VERT = 3;
    localparam int VTX_WORDS       = VERTS_PER_TRI * COORDS_PER_VERT;

endpackage

// File: rtl/triangle_fetcher_reg_32.sv
// 32-bit holding register with load enable, used for each vertex word.
module reg_32 (
    input  logic        clk,
    input  logic        sreset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (sreset)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/triangle_fetcher.sv
// Fetches each triangle's nine vertex words, hands them to the shader, and
// streams the shaded result (index + color) to the rasterizer.
module triangle_fetcher #(
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_TRI = triangle_fetcher_pkg::WORDS_PER_TRI
) (
    input  logic              clk,
    input  logic              sreset,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] tri_count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [2:0][31:0]  p1,
    output logic [2:0][31:0]  p2,
    output logic [2:0][31:0]  p3,
    output logic              shade_start,
    input  logic              shade_done,
    input  logic [3:0]        shade_color,
    output logic              tri_valid,
    input  logic              tri_ready,
    output logic [3:0]        tri_color,
    output logic [ADDR_W-1:0] tri_index,
    output logic              busy,
    output logic              batch_done
);
    import triangle_fetcher_pkg::*;

    localparam int K_W = $clog2(VTX_WORDS + 2);

    state_e                        state_q, state_d;
    logic [ADDR_W-1:0]             tri_base_q, tri_base_d;
    logic [ADDR_W-1:0]             count_q, count_d;
    logic [ADDR_W-1:0]             n_q, n_d;
    logic [K_W-1:0]                k_q, k_d;
    logic [3:0]                    color_q, color_d;
    logic [VTX_WORDS-1:0]          vtx_en;
    logic [VTX_WORDS-1:0][31:0]    vtx_q;

    logic accept, xfer, last_tri, fetch_issue;

    assign accept      = (state_q == IDLE) && go;
    assign xfer        = (state_q == EMIT) && tri_ready;
    assign last_tri    = (n_q + ADDR_W'(1)) == count_q;
    assign fetch_issue = (state_q == FETCH) && (k_q < K_W'(VTX_WORDS));

    always_ff @(posedge clk) begin
        if (sreset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (go) state_d = (tri_count != '0) ? FETCH : FINISH;
            // Final FETCH cycle only captures the last read's data
            FETCH:       if (k_q == K_W'(VTX_WORDS)) state_d = SHADE_START;
            SHADE_START: state_d = SHADE_WAIT;
            SHADE_WAIT:  if (shade_done) state_d = EMIT;
            EMIT:        if (tri_ready) state_d = last_tri ? FINISH : FETCH;
            FINISH:      state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rd      = fetch_issue;
        mem_addr    = fetch_issue ? tri_base_q + ADDR_W'(k_q) : '0;
        shade_start = (state_q == SHADE_START);
        tri_valid   = (state_q == EMIT);
        busy        = (state_q != IDLE);
        batch_done  = (state_q == FINISH);
    end

    always_comb begin
        tri_base_d = tri_base_q;
        count_d    = count_q;
        n_d        = n_q;
        k_d        = (state_q == FETCH) ? k_q + K_W'(1) : '0;
        color_d    = color_q;
        if (accept) begin
            tri_base_d = base_addr;
            count_d    = tri_count;
            n_d        = '0;
        end
        if (xfer) begin
            tri_base_d = tri_base_q + ADDR_W'(WORDS_PER_TRI);
            n_d        = n_q + ADDR_W'(1);
        end
        if ((state_q == SHADE_WAIT) && shade_done) color_d = shade_color;
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            tri_base_q <= '0;
            count_q    <= '0;
            n_q        <= '0;
            k_q        <= '0;
            color_q    <= '0;
        end else begin
            tri_base_q <= tri_base_d;
            count_q    <= count_d;
            n_q        <= n_d;
            k_q        <= k_d;
            color_q    <= color_d;
        end
    end

    // Word k arrives the cycle after its read, i.e. while k_q == k+1
    for (genvar i = 0; i < VTX_WORDS; i++) begin : g_vtx
        assign vtx_en[i] = (state_q == FETCH) && (k_q == K_W'(i + 1));
        reg_32 u_word (
            .clk    (clk),
            .sreset (sreset),
            .en     (vtx_en[i]),
            .d      (mem_rdata),
            .q      (vtx_q[i])
        );
    end

    assign p1        = vtx_q[2:0];
    assign p2        = vtx_q[5:3];
    assign p3        = vtx_q[8:6];
    assign tri_color = color_q;
    assign tri_index = n_q;

endmodule

// File: tb/tb_triangle_fetcher.sv
// Randomized self-checking bench for triangle_fetcher with memory, shader
// and rasterizer models plus a per-batch reference of expected traffic.
module tb_triangle_fetcher;

    typedef struct packed {
        logic [15:0]       idx;
        logic [3:0]        col;
        logic [8:0][31:0]  w;
        logic [31:0]       cyc;
    } xfer_t;

    logic              clk = 1'b0;
    logic              sreset, go;
    logic [15:0]       base_addr, tri_count;
    logic              mem_rd;
    logic [15:0]       mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic [2:0][31:0]  p1, p2, p3;
    logic              shade_start, shade_done;
    logic [3:0]        shade_color;
    logic              tri_valid, tri_ready;
    logic [3:0]        tri_color;
    logic [15:0]       tri_index;
    logic              busy, batch_done;

    triangle_fetcher #(.ADDR_W(16), .WORDS_PER_TRI(9)) dut (
        .clk(clk), .sreset(sreset), .go(go), .base_addr(base_addr), .tri_count(tri_count),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .p1(p1), .p2(p2), .p3(p3), .shade_start(shade_start), .shade_done(shade_done),
        .shade_color(shade_color), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_color(tri_color), .tri_index(tri_index), .busy(busy), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          ss_cnt = 0, bd_cnt = 0, addr_bad = 0, stab_bad = 0;
    int          rdy_mode = 2;
    logic [31:0] cyc = 0, bd_cyc = 0, go_cyc = 0;
    logic [31:0] mem_off = 32'h1234_0000;
    logic [15:0] rd_q[$];
    xfer_t       xf_q[$];
    logic [3:0]  col_q[$];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return mem_off + {16'h0, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : 32'h0;

    // Passive observer: read addresses, transfers, pulses, protocol rules
    logic             pv_v = 1'b0, pv_r = 1'b0;
    logic [3:0]       pv_col;
    logic [15:0]      pv_idx;
    logic [8:0][31:0] pv_w;
    xfer_t            xt;
    always @(negedge clk) begin
        if (sreset) pv_v = 1'b0;
        else begin
            if (mem_rd) rd_q.push_back(mem_addr);
            else if (mem_addr !== 16'h0) addr_bad++;
            if (shade_start) ss_cnt++;
            if (batch_done) begin bd_cnt++; bd_cyc = cyc; end
            if (pv_v && !pv_r)
                if (!tri_valid || tri_color !== pv_col || tri_index !== pv_idx || {p3, p2, p1} !== pv_w)
                    stab_bad++;
            if (tri_valid && tri_ready) begin
                xt.idx = tri_index; xt.col = tri_color; xt.w = {p3, p2, p1}; xt.cyc = cyc;
                xf_q.push_back(xt);
            end
            pv_v = tri_valid; pv_r = tri_ready; pv_col = tri_color; pv_idx = tri_index;
            pv_w = {p3, p2, p1};
        end
    end

    // Shader model: answers each start after 1..4 cycles with the next queued color
    initial begin
        int dly;
        logic [3:0] c;
        shade_done = 1'b0; shade_color = 4'h0;
        forever begin
            @(negedge clk);
            if (shade_start === 1'b1 && !sreset) begin
                dly = $urandom_range(1, 4);
                c = (col_q.size() > 0) ? col_q.pop_front() : 4'($urandom);
                repeat (dly) @(posedge clk);
                #1 shade_done = 1'b1; shade_color = c;
                @(posedge clk);
                #1 shade_done = 1'b0; shade_color = 4'($urandom);
            end
        end
    end

    initial begin
        tri_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tri_ready = 1'($urandom_range(0, 1));
                1:       tri_ready = 1'b0;
                default: tri_ready = 1'b1;
            endcase
        end
    end

    task automatic start_batch(input logic [15:0] b, input logic [15:0] c);
        rd_q.delete(); xf_q.delete();
        ss_cnt = 0; bd_cnt = 0; addr_bad = 0; stab_bad = 0;
        @(posedge clk); #1;
        base_addr = b; tri_count = c; go = 1'b1; go_cyc = cyc;
        @(posedge clk); #1;
        go = 1'b0; base_addr = 16'($urandom); tri_count = 16'($urandom);
    endtask

    task automatic wait_batch(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bd_cnt > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        sreset = 1'b1; go = 1'b0; base_addr = '0; tri_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({mem_rd, mem_addr, shade_start, tri_valid, tri_color, tri_index, busy, batch_done} !== '0) begin
            n_err++; $display("FAIL reset_ctrl: got %0h required 0",
                {mem_rd, mem_addr, shade_start, tri_valid, tri_color, tri_index, busy, batch_done});
        end
        n_cmp++;
        if ({p3, p2, p1} !== '0) begin n_err++; $display("FAIL reset_verts: got %0h required 0", {p3, p2, p1}); end
        @(posedge clk); #1 go = 1'b1; tri_count = 16'd3;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_over_go: busy %0b required 0", busy); end
        @(posedge clk); #1 go = 1'b0; sreset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy %0b required 0", busy); end
    endtask

    task automatic test_single;
        bit ok;
        mem_off = 32'h3F80_0000 - 32'h0100; rdy_mode = 2;
        col_q.delete(); col_q.push_back(4'h7);
        start_batch(16'h0100, 16'd1);
        wait_batch(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: batch_done %0b required 1", ok); end
        n_cmp++; if (rd_q.size() !== 9) begin n_err++; $display("FAIL single_nreads: got %0d required 9", rd_q.size()); end
        for (int k = 0; k < 9 && k < rd_q.size(); k++) begin
            n_cmp++;
            if (rd_q[k] !== 16'(16'h0100 + k)) begin
                n_err++; $display("FAIL single_addr%0d: got %0h required %0h", k, rd_q[k], 16'(16'h0100 + k));
            end
        end
        n_cmp++;
        if (xf_q.size() !== 1) begin n_err++; $display("FAIL single_nxfer: got %0d required 1", xf_q.size()); end
        else begin
            n_cmp++;
            if (xf_q[0].w[0] !== 32'h3F80_0000 || xf_q[0].w[8] !== 32'h3F80_0008) begin
                n_err++; $display("FAIL single_p: p1x %0h p3z %0h required 3f800000 3f800008", xf_q[0].w[0], xf_q[0].w[8]);
            end
            n_cmp++;
            if (xf_q[0].idx !== 16'd0 || xf_q[0].col !== 4'h7) begin
                n_err++; $display("FAIL single_res: idx %0d col %0h required 0 7", xf_q[0].idx, xf_q[0].col);
            end
            n_cmp++;
            if (bd_cyc !== xf_q[0].cyc + 1) begin
                n_err++; $display("FAIL single_done_time: got %0d required %0d", bd_cyc, xf_q[0].cyc + 1);
            end
        end
        n_cmp++; if (ss_cnt !== 1) begin n_err++; $display("FAIL single_starts: got %0d required 1", ss_cnt); end
        n_cmp++; if (addr_bad !== 0) begin n_err++; $display("FAIL single_idle_addr: got %0d required 0", addr_bad); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %0b required 0", busy); end
    endtask

    task automatic test_multi;
        bit ok;
        logic [3:0] cols[3];
        logic [8:0][31:0] ew;
        cols = '{4'd5, 4'd9, 4'd2};
        mem_off = $urandom; rdy_mode = 0;
        col_q.delete(); foreach (cols[i]) col_q.push_back(cols[i]);
        start_batch(16'h0000, 16'd3);
        wait_batch(600, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL multi_timeout: batch_done %0b required 1", ok); end
        n_cmp++;
        if (rd_q.size() !== 27) begin n_err++; $display("FAIL multi_nreads: got %0d required 27", rd_q.size()); end
        else begin
            n_cmp++;
            if (rd_q[18] !== 16'h0012) begin n_err++; $display("FAIL multi_third_addr: got %0h required 12", rd_q[18]); end
        end
        n_cmp++;
        if (xf_q.size() !== 3) begin n_err++; $display("FAIL multi_nxfer: got %0d required 3", xf_q.size()); end
        else for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 9; k++) ew[k] = mem_word(16'(9 * n + k));
            n_cmp++;
            if (xf_q[n].idx !== 16'(n) || xf_q[n].col !== cols[n] || xf_q[n].w !== ew) begin
                n_err++; $display("FAIL multi_tri%0d: idx %0d col %0d required %0d %0d", n, xf_q[n].idx, xf_q[n].col, n, cols[n]);
            end
        end
        n_cmp++; if (ss_cnt !== 3) begin n_err++; $display("FAIL multi_starts: got %0d required 3", ss_cnt); end
        n_cmp++; if (stab_bad !== 0) begin n_err++; $display("FAIL multi_stable: got %0d required 0", stab_bad); end
    endtask

    task automatic test_stall;
        bit ok;
        logic [31:0] c0;
        logic [3:0]  s_col;
        logic [15:0] s_idx;
        logic [8:0][31:0] s_w;
        mem_off = $urandom; rdy_mode = 1;
        col_q.delete(); col_q.push_back(4'hC);
        start_batch(16'h2000, 16'd1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin @(negedge clk); if (tri_valid) begin ok = 1'b1; break; end end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_valid_timeout: tri_valid %0b required 1", ok); end
        s_col = tri_color; s_idx = tri_index; s_w = {p3, p2, p1};
        repeat (20) @(negedge clk);
        n_cmp++;
        if (tri_valid !== 1'b1 || tri_color !== 4'hC || tri_index !== s_idx || {p3, p2, p1} !== s_w) begin
            n_err++; $display("FAIL stall_hold: valid %0b col %0h required 1 c", tri_valid, tri_color);
        end
        n_cmp++; if (xf_q.size() !== 0) begin n_err++; $display("FAIL stall_early_xfer: got %0d required 0", xf_q.size()); end
        c0 = cyc; rdy_mode = 2;
        wait_batch(20, ok);
        n_cmp++;
        if (xf_q.size() !== 1) begin n_err++; $display("FAIL stall_nxfer: got %0d required 1", xf_q.size()); end
        else begin
            n_cmp++;
            if (xf_q[0].cyc !== c0 + 1 || xf_q[0].col !== s_col) begin
                n_err++; $display("FAIL stall_xfer_cycle: got %0d required %0d", xf_q[0].cyc, c0 + 1);
            end
        end
        n_cmp++; if (stab_bad !== 0) begin n_err++; $display("FAIL stall_stable: got %0d required 0", stab_bad); end
    endtask

    task automatic test_zero;
        rdy_mode = 0;
        start_batch(16'h0040, 16'd0);
        repeat (15) @(negedge clk);
        n_cmp++;
        if (bd_cnt !== 1 || bd_cyc !== go_cyc + 1) begin
            n_err++; $display("FAIL zero_done: count %0d cycle %0d required 1 %0d", bd_cnt, bd_cyc, go_cyc + 1);
        end
        n_cmp++;
        if (rd_q.size() !== 0 || ss_cnt !== 0) begin
            n_err++; $display("FAIL zero_activity: reads %0d starts %0d required 0 0", rd_q.size(), ss_cnt);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [8:0][31:0] ew;
        mem_off = $urandom; rdy_mode = 2;
        col_q.delete(); col_q.push_back(4'h3);
        start_batch(16'hFFFC, 16'd1);
        wait_batch(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: batch_done %0b required 1", ok); end
        n_cmp++;
        if (rd_q.size() !== 9) begin n_err++; $display("FAIL wrap_nreads: got %0d required 9", rd_q.size()); end
        else for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (rd_q[k] !== 16'(16'hFFFC + k)) begin
                n_err++; $display("FAIL wrap_addr%0d: got %0h required %0h", k, rd_q[k], 16'(16'hFFFC + k));
            end
        end
        for (int k = 0; k < 9; k++) ew[k] = mem_word(16'(16'hFFFC + k));
        n_cmp++;
        if (xf_q.size() !== 1 || xf_q[0].w !== ew) begin
            n_err++; $display("FAIL wrap_verts: xfers %0d required 1 with wrapped data", xf_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int hits;
        logic [15:0] b2;
        logic [8:0][31:0] ew;
        mem_off = $urandom; rdy_mode = 2;
        col_q.delete();
        start_batch(16'h1111, 16'd2);
        hits = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_rd) hits++;
            if (hits == 5) break;
        end
        sreset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, mem_rd, mem_addr, shade_start, tri_valid, tri_color, tri_index, batch_done} !== '0 || {p3, p2, p1} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: busy %0b rd %0b addr %0h required all 0", busy, mem_rd, mem_addr);
        end
        sreset = 1'b0;
        b2 = 16'($urandom);
        col_q.push_back(4'hA);
        start_batch(b2, 16'd1);
        wait_batch(200, ok);
        n_cmp++;
        if (!ok || rd_q.size() !== 9) begin
            n_err++; $display("FAIL midreset_refetch: done %0b reads %0d required 1 9", ok, rd_q.size());
        end else begin
            n_cmp++;
            if (rd_q[0] !== b2 || rd_q[8] !== 16'(b2 + 8)) begin
                n_err++; $display("FAIL midreset_base: got %0h required %0h", rd_q[0], b2);
            end
        end
        for (int k = 0; k < 9; k++) ew[k] = mem_word(16'(b2 + k));
        n_cmp++;
        if (xf_q.size() !== 1 || xf_q[0].w !== ew || xf_q[0].idx !== 16'd0 || xf_q[0].col !== 4'hA) begin
            n_err++; $display("FAIL midreset_result: xfers %0d required 1 idx 0 col a", xf_q.size());
        end
    endtask

    task automatic test_random;
        bit ok;
        logic [15:0] b;
        int cnt;
        logic [3:0] cols[$];
        logic [8:0][31:0] ew;
        for (int it = 0; it < 5; it++) begin
            b = 16'($urandom); cnt = $urandom_range(1, 4); mem_off = $urandom; rdy_mode = 0;
            cols.delete(); col_q.delete();
            for (int n = 0; n < cnt; n++) begin cols.push_back(4'($urandom)); col_q.push_back(cols[n]); end
            start_batch(b, 16'(cnt));
            @(posedge clk); #1 go = 1'b1; base_addr = 16'($urandom); tri_count = 16'd7;
            @(posedge clk); #1 go = 1'b0;
            wait_batch(100 * cnt + 50, ok);
            repeat (3) @(negedge clk);
            n_cmp++;
            if (!ok || bd_cnt !== 1 || busy !== 1'b0) begin
                n_err++; $display("FAIL rand%0d_done: done %0b count %0d busy %0b required 1 1 0", it, ok, bd_cnt, busy);
            end
            n_cmp++;
            if (rd_q.size() !== 9 * cnt || xf_q.size() !== cnt) begin
                n_err++; $display("FAIL rand%0d_sizes: reads %0d xfers %0d required %0d %0d", it, rd_q.size(), xf_q.size(), 9 * cnt, cnt);
            end else for (int n = 0; n < cnt; n++) begin
                for (int k = 0; k < 9; k++) ew[k] = mem_word(16'(b + 9 * n + k));
                n_cmp++;
                if (rd_q[9 * n] !== 16'(b + 9 * n) || xf_q[n].w !== ew || xf_q[n].idx !== 16'(n) || xf_q[n].col !== cols[n]) begin
                    n_err++; $display("FAIL rand%0d_tri%0d: addr %0h idx %0d col %0h required %0h %0d %0h",
                        it, n, rd_q[9 * n], xf_q[n].idx, xf_q[n].col, 16'(b + 9 * n), n, cols[n]);
                end
            end
            n_cmp++;
            if (stab_bad !== 0 || addr_bad !== 0 || ss_cnt !== cnt) begin
                n_err++; $display("FAIL rand%0d_protocol: unstable %0d idle_addr %0d starts %0d required 0 0 %0d",
                    it, stab_bad, addr_bad, ss_cnt, cnt);
            end
        end
    endtask

    initial begin
        sreset = 1'b1; go = 1'b0; base_addr = '0; tri_count = '0;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
